// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// Pipeline MEM stage between execute and write-back. It takes one instruction
// at a time from execute. Loads and stores go to the data cache over a
// valid/ready request channel, and load data comes back on a separate response
// channel. Load data is sign- or zero-extended. The stage hands the result, the
// ALU result and the control bundle to write-back with a one-cycle
// o_wb_module_enable pulse. Non-memory instructions pass through in one cycle.
//
// Ports
//   i_clk                 : clock, all state updates on the rising edge
//   i_reset               : asynchronous active-high reset
//   i_mem_module_enable   : execute presents a valid instruction
//   i_alu_result          : ALU result / effective address
//   i_store_data          : rs2 value for stores
//   i_control_signals     : control bundle (opcode, funct3, dest_reg, pc)
//   o_mem_ready           : stage can accept an instruction this cycle
//   o_dcache_req_valid    : cache request valid
//   i_dcache_req_ready    : cache accepts the request
//   o_dcache_req_addr     : doubleword-aligned request address
//   o_dcache_req_write    : 1 = store, 0 = load
//   o_dcache_req_wdata    : lane-shifted store data
//   o_dcache_req_wstrb    : store byte strobes
//   i_dcache_resp_valid   : load data returned
//   i_dcache_resp_data    : aligned doubleword from the cache
//   o_wb_module_enable    : one-cycle pulse, results valid in that cycle
//   o_alu_result_out      : registered ALU result
//   o_loaded_data         : extended load result
//   o_control_signals_out : registered control bundle
// -----------------------------------------------------------------------------

package memory_access_stage_pkg;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  dest_reg;
        logic [63:0] pc;
    } control_signals_struct;

endpackage

module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_mem_module_enable,
    input  logic [63:0]           i_alu_result,
    input  logic [63:0]           i_store_data,
    input  control_signals_struct i_control_signals,
    output logic                  o_mem_ready,
    output logic                  o_dcache_req_valid,
    input  logic                  i_dcache_req_ready,
    output logic [63:0]           o_dcache_req_addr,
    output logic                  o_dcache_req_write,
    output logic [63:0]           o_dcache_req_wdata,
    output logic [7:0]            o_dcache_req_wstrb,
    input  logic                  i_dcache_resp_valid,
    input  logic [63:0]           i_dcache_resp_data,
    output logic                  o_wb_module_enable,
    output logic [63:0]           o_alu_result_out,
    output logic [63:0]           o_loaded_data,
    output control_signals_struct o_control_signals_out
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // -------------------------------------------------------------------------
    // Load data extraction: shift the addressed byte lane down to bit 0, then
    // sign- or zero-extend according to funct3. funct3 = 111 yields zero.
    // -------------------------------------------------------------------------
    function automatic logic [63:0] f_load_extend(
        input logic [63:0] data,
        input logic [2:0]  off,
        input logic [2:0]  funct3
    );
        logic [63:0] sh;
        logic [63:0] res;
        sh = data >> {off, 3'b000};
        case (funct3)
            3'b000:  res = {{56{sh[7]}},  sh[7:0]};
            3'b001:  res = {{48{sh[15]}}, sh[15:0]};
            3'b010:  res = {{32{sh[31]}}, sh[31:0]};
            3'b011:  res = sh;
            3'b100:  res = {56'd0, sh[7:0]};
            3'b101:  res = {48'd0, sh[15:0]};
            3'b110:  res = {32'd0, sh[31:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Store byte strobes. The base mask comes from the access size and is
    // shifted to the byte offset. Lanes that fall past byte 7 are dropped on
    // purpose: misaligned stores are not detected, only truncated.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] f_store_strobe(
        input logic [2:0] funct3,
        input logic [2:0] off
    );
        logic [7:0] base;
        case (funct3)
            3'b000:  base = 8'h01;
            3'b001:  base = 8'h03;
            3'b010:  base = 8'h0F;
            3'b011:  base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Store data moved to the addressed byte lanes. Upper bytes are truncated.
    function automatic logic [63:0] f_store_data(
        input logic [63:0] data,
        input logic [2:0]  off
    );
        return data << {off, 3'b000};
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_mem_ready;
    logic                  r_req_valid;
    logic                  r_req_write;
    logic [63:0]           r_req_addr;
    logic [63:0]           r_req_wdata;
    logic [7:0]            r_req_wstrb;
    logic                  r_wb_enable;
    logic [63:0]           r_alu_result;
    logic [63:0]           r_loaded_data;
    control_signals_struct r_ctrl;

    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_mem;
    logic                  w_load_done;

    assign w_accept    = i_mem_module_enable & r_mem_ready;
    assign w_is_load   = (i_control_signals.opcode == OPC_LOAD);
    assign w_is_store  = (i_control_signals.opcode == OPC_STORE);
    assign w_is_mem    = w_is_load | w_is_store;
    // A response only counts while a load is waiting for it. Responses that
    // arrive in any other state, including stale ones after a reset, are dropped.
    assign w_load_done = (r_state == S_WAIT) & i_dcache_resp_valid;

    // Next-state logic for the IDLE / REQ / WAIT / OUT sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_OUT: begin
                // OUT accepts like IDLE so pass-through ops run back to back.
                if (w_accept) begin
                    if (w_is_mem) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_OUT;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_dcache_req_ready) begin
                    if (r_req_write) begin
                        w_next_state = S_OUT;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_WAIT: begin
                if (i_dcache_resp_valid) begin
                    w_next_state = S_OUT;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and the handshake flags. The flags are decoded from the
    // next state so that they are registered outputs aligned with the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_mem_ready <= 1'b1;
            r_req_valid <= 1'b0;
            r_wb_enable <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_ready <= (w_next_state == S_IDLE) || (w_next_state == S_OUT);
            r_req_valid <= (w_next_state == S_REQ);
            r_wb_enable <= (w_next_state == S_OUT);
        end
    end

    // Capture the accepted instruction's ALU result and control bundle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alu_result <= 64'd0;
            r_ctrl       <= '0;
        end else if (w_accept) begin
            r_alu_result <= i_alu_result;
            r_ctrl       <= i_control_signals;
        end
    end

    // Build the cache request fields once, at acceptance. They stay unchanged
    // through any backpressure because nothing is accepted while mem_ready=0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req_addr  <= 64'd0;
            r_req_write <= 1'b0;
            r_req_wdata <= 64'd0;
            r_req_wstrb <= 8'h00;
        end else if (w_accept && w_is_mem) begin
            r_req_addr  <= {i_alu_result[63:3], 3'b000};
            r_req_write <= w_is_store;
            if (w_is_store) begin
                r_req_wdata <= f_store_data(i_store_data, i_alu_result[2:0]);
                r_req_wstrb <= f_store_strobe(i_control_signals.funct3,
                                              i_alu_result[2:0]);
            end else begin
                r_req_wdata <= 64'd0;
                r_req_wstrb <= 8'h00;
            end
        end
    end

    // Load result register. Only a completed load updates it. The byte offset
    // comes from the captured address, because upstream may have moved on.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_loaded_data <= 64'd0;
        end else if (w_load_done) begin
            r_loaded_data <= f_load_extend(i_dcache_resp_data,
                                           r_alu_result[2:0],
                                           r_ctrl.funct3);
        end
    end

    assign o_mem_ready           = r_mem_ready;
    assign o_dcache_req_valid    = r_req_valid;
    assign o_dcache_req_addr     = r_req_addr;
    assign o_dcache_req_write    = r_req_write;
    assign o_dcache_req_wdata    = r_req_wdata;
    assign o_dcache_req_wstrb    = r_req_wstrb;
    assign o_wb_module_enable    = r_wb_enable;
    assign o_alu_result_out      = r_alu_result;
    assign o_loaded_data         = r_loaded_data;
    assign o_control_signals_out = r_ctrl;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage with hand-computed expectations.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mem_en;
    logic [63:0]           alu;
    logic [63:0]           sdata;
    control_signals_struct ctrl;
    logic                  mem_ready;
    logic                  req_valid;
    logic                  req_ready;
    logic [63:0]           req_addr;
    logic                  req_write;
    logic [63:0]           req_wdata;
    logic [7:0]            req_wstrb;
    logic                  resp_valid;
    logic [63:0]           resp_data;
    logic                  wb_en;
    logic [63:0]           alu_out;
    logic [63:0]           loaded;
    control_signals_struct ctrl_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_mem_module_enable   (mem_en),
        .i_alu_result          (alu),
        .i_store_data          (sdata),
        .i_control_signals     (ctrl),
        .o_mem_ready           (mem_ready),
        .o_dcache_req_valid    (req_valid),
        .i_dcache_req_ready    (req_ready),
        .o_dcache_req_addr     (req_addr),
        .o_dcache_req_write    (req_write),
        .o_dcache_req_wdata    (req_wdata),
        .o_dcache_req_wstrb    (req_wstrb),
        .i_dcache_resp_valid   (resp_valid),
        .i_dcache_resp_data    (resp_data),
        .o_wb_module_enable    (wb_en),
        .o_alu_result_out      (alu_out),
        .o_loaded_data         (loaded),
        .o_control_signals_out (ctrl_out)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] opc, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sd,
                           input logic [4:0] rd);
        mem_en         = 1'b1;
        alu            = addr;
        sdata          = sd;
        ctrl.opcode    = opc;
        ctrl.funct3    = f3;
        ctrl.dest_reg  = rd;
        ctrl.pc        = 64'h8000_0000 + addr;
    endtask

    // Load with ready and response each after one cycle: the pulse comes 3 cycles after the accept.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [63:0] exp_addr,
                            input logic [2:0] f3, input logic [63:0] rdata, input logic [63:0] exp);
        present(7'b0000011, f3, addr, 64'd0, 5'd7);
        tick;
        mem_en = 1'b0;
        check_val({tag, " req_valid"}, {63'd0, req_valid}, 64'd1);
        check_val({tag, " req_addr"}, req_addr, exp_addr);
        check_val({tag, " req_write"}, {63'd0, req_write}, 64'd0);
        check_val({tag, " mem_ready"}, {63'd0, mem_ready}, 64'd0);
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check_val({tag, " valid_drop"}, {63'd0, req_valid}, 64'd0);
        check_val({tag, " no_early_wb"}, {63'd0, wb_en}, 64'd0);
        resp_valid = 1'b1;
        resp_data  = rdata;
        tick;
        resp_valid = 1'b0;
        check_val({tag, " wb_pulse"}, {63'd0, wb_en}, 64'd1);
        check_val({tag, " loaded"}, loaded, exp);
        check_val({tag, " alu_out"}, alu_out, addr);
        tick;
        check_val({tag, " wb_end"}, {63'd0, wb_en}, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        mem_en     = 1'b0;
        alu        = 64'd0;
        sdata      = 64'd0;
        ctrl       = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 64'd0;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state
        check_val("rst mem_ready", {63'd0, mem_ready}, 64'd1);
        check_val("rst req_valid", {63'd0, req_valid}, 64'd0);
        check_val("rst req_write", {63'd0, req_write}, 64'd0);
        check_val("rst req_addr", req_addr, 64'd0);
        check_val("rst req_wdata", req_wdata, 64'd0);
        check_val("rst req_wstrb", {56'd0, req_wstrb}, 64'd0);
        check_val("rst wb", {63'd0, wb_en}, 64'd0);
        check_val("rst alu_out", alu_out, 64'd0);
        check_val("rst loaded", loaded, 64'd0);
        check_val("rst ctrl_pc", ctrl_out.pc, 64'd0);

        // Back-to-back pass-through ADDI
        present(7'b0010011, 3'b000, 64'h10, 64'd0, 5'd3);
        tick;
        check_val("addi1 wb", {63'd0, wb_en}, 64'd1);
        check_val("addi1 alu_out", alu_out, 64'h10);
        check_val("addi1 ready", {63'd0, mem_ready}, 64'd1);
        check_val("addi1 rd", {59'd0, ctrl_out.dest_reg}, 64'd3);
        present(7'b0010011, 3'b000, 64'h20, 64'd0, 5'd4);
        tick;
        mem_en = 1'b0;
        check_val("addi2 wb", {63'd0, wb_en}, 64'd1);
        check_val("addi2 alu_out", alu_out, 64'h20);
        check_val("addi2 ready", {63'd0, mem_ready}, 64'd1);
        check_val("addi2 pc", ctrl_out.pc, 64'h8000_0020);
        tick;
        check_val("addi idle wb", {63'd0, wb_en}, 64'd0);
        check_val("addi idle req", {63'd0, req_valid}, 64'd0);

        // Loads: sign/zero extension and offsets
        run_load("lb",  64'h1003, 64'h1000, 3'b000, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lhu", 64'h2002, 64'h2000, 3'b101, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
        run_load("lh",  64'h2002, 64'h2000, 3'b001, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        run_load("lwu", 64'h0004, 64'h0000, 3'b110, 64'hF000_0000_0000_0000, 64'h0000_0000_F000_0000);
        run_load("lw",  64'h0004, 64'h0000, 3'b010, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_F000_0000);
        run_load("ld",  64'h0008, 64'h0008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        run_load("f3_7", 64'h0008, 64'h0008, 3'b111, 64'h0123_4567_89AB_CDEF, 64'd0);

        // SH with 4 cycles of request backpressure
        present(7'b0100011, 3'b001, 64'h3005, 64'hABCD, 5'd0);
        tick;
        mem_en = 1'b0;
        alu    = 64'hDEAD_BEEF;
        sdata  = 64'h5555;
        for (int i = 0; i < 4; i++) begin
            check_val("sh stall valid", {63'd0, req_valid}, 64'd1);
            check_val("sh stall ready", {63'd0, mem_ready}, 64'd0);
            check_val("sh stall write", {63'd0, req_write}, 64'd1);
            check_val("sh stall addr", req_addr, 64'h3000);
            check_val("sh stall wdata", req_wdata, 64'h00AB_CD00_0000_0000);
            check_val("sh stall wstrb", {56'd0, req_wstrb}, 64'h60);
            check_val("sh stall wb", {63'd0, wb_en}, 64'd0);
            tick;
        end
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check_val("sh wb", {63'd0, wb_en}, 64'd1);
        check_val("sh valid_drop", {63'd0, req_valid}, 64'd0);
        check_val("sh ready", {63'd0, mem_ready}, 64'd1);
        check_val("sh loaded_hold", loaded, 64'd0);
        tick;
        check_val("sh wb_end", {63'd0, wb_en}, 64'd0);

        // SW at offset 6: lanes past byte 7 dropped
        present(7'b0100011, 3'b010, 64'h4006, 64'h1122_3344, 5'd0);
        tick;
        mem_en = 1'b0;
        check_val("sw wdata", req_wdata, 64'h3344_0000_0000_0000);
        check_val("sw wstrb", {56'd0, req_wstrb}, 64'hC0);
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check_val("sw wb", {63'd0, wb_en}, 64'd1);
        tick;

        // Reset while in WAIT, then a stale response
        present(7'b0000011, 3'b011, 64'h5000, 64'd0, 5'd9);
        tick;
        mem_en    = 1'b0;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check_val("wait ready", {63'd0, mem_ready}, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check_val("rstw async ready", {63'd0, mem_ready}, 64'd1);
        check_val("rstw async valid", {63'd0, req_valid}, 64'd0);
        tick;
        reset      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 64'h0000_0000_DEAD_BEEF;
        tick;
        check_val("rstw stale wb1", {63'd0, wb_en}, 64'd0);
        tick;
        resp_valid = 1'b0;
        check_val("rstw stale wb2", {63'd0, wb_en}, 64'd0);
        check_val("rstw ready", {63'd0, mem_ready}, 64'd1);
        check_val("rstw valid", {63'd0, req_valid}, 64'd0);
        check_val("rstw loaded", loaded, 64'd0);
        check_val("rstw alu_out", alu_out, 64'd0);
        check_val("rstw addr", req_addr, 64'd0);
        check_val("rstw wdata", req_wdata, 64'd0);
        check_val("rstw wstrb", {56'd0, req_wstrb}, 64'd0);
        check_val("rstw ctrl_pc", ctrl_out.pc, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage sitting between execute and the write-back stage. It accepts one instruction at a time from execute and issues loads and stores to the data cache over a valid/ready request channel with a separate response channel. It sign- or zero-extends load data and presents the result, the ALU result and the control bundle to write-back with a one-cycle `wb_module_enable` pulse. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters. Data width is fixed at 64 bits and address width at 64 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `mem_module_enable` in 1: execute presents a valid instruction this cycle.
- `alu_result` in 64: ALU result; this is the effective address for loads and stores.
- `store_data` in 64: rs2 value for stores.
- `control_signals` in control_signals_struct: the fields used are `opcode`, `funct3`, `dest_reg` and `pc`.
- `mem_ready` out 1: stage can accept an instruction this cycle.
- `dcache_req_valid` out 1: request valid.
- `dcache_req_ready` in 1: cache accepts the request.
- `dcache_req_addr` out 64: doubleword-aligned address, `{alu_result[63:3], 3'b0}`.
- `dcache_req_write` out 1: 1 = store, 0 = load.
- `dcache_req_wdata` out 64: lane-shifted store data.
- `dcache_req_wstrb` out 8: byte strobes for the store.
- `dcache_resp_valid` in 1: load data returned.
- `dcache_resp_data` in 64: aligned doubleword.
- `wb_module_enable` out 1: one-cycle pulse; the result outputs are valid in that cycle.
- `alu_result_out` out 64: registered ALU result.
- `loaded_data` out 64: extended load result.
- `control_signals_out` out control_signals_struct: registered control bundle.

## Operation
- Instruction classes:
  - Load: opcode 0000011.
  - Store: opcode 0100011.
  - Everything else is pass-through.
- FSM states and transitions:
  - IDLE: `mem_ready`=1. An accepted instruction moves to REQ if it is a load or store, otherwise to OUT.
  - REQ: `dcache_req_valid`=1 and the request fields are held stable. When `dcache_req_ready`=1, a load moves to WAIT and a store moves to OUT.
  - WAIT: the stage waits for `dcache_resp_valid`. On the response it captures the extended data and moves to OUT.
  - OUT: `wb_module_enable`=1 and `mem_ready`=1. An accept in this state follows the IDLE rules; with no accept the FSM returns to IDLE.
- Acceptance:
  - An instruction is accepted when `mem_module_enable & mem_ready`.
  - The stage captures `alu_result`, `store_data` and `control_signals` into registers on acceptance.
  - While `mem_ready`=0, upstream holds its inputs; enable is ignored.
- Load extraction:
  - The byte offset is `off = alu_result[2:0]`.
  - The shifted word is `sh = dcache_resp_data >> (8*off)`.
  - Extension by `funct3`:
    - 000 LB: sign-extend `sh[7:0]`.
    - 001 LH: sign-extend `sh[15:0]`.
    - 010 LW: sign-extend `sh[31:0]`.
    - 011 LD: `sh` unchanged.
    - 100 LBU, 101 LHU, 110 LWU: zero-extend.
    - 111: result is 0.
- Store lanes:
  - Write data is `wdata = store_data << (8*off)`.
  - Base strobe by `funct3`: 000 → 8'h01, 001 → 8'h03, 010 → 8'h0F, 011 → 8'hFF.
  - The base strobe is shifted left by `off` and truncated to 8 bits.
  - Misalignment is not detected; lanes beyond byte 7 are dropped.
- `loaded_data`:
  - Updated only by loads.
  - Holds its value otherwise.
  - For non-load instructions write-back ignores it.
- A `dcache_resp_valid` arriving in any state other than WAIT is ignored.

## Timing
- Reset values:
  - FSM state is IDLE and `mem_ready`=1.
  - `dcache_req_valid`=0, `dcache_req_write`=0, `dcache_req_addr`=0, `dcache_req_wdata`=0, `dcache_req_wstrb`=0.
  - `wb_module_enable`=0, `alu_result_out`=0, `loaded_data`=0, `control_signals_out`=0.
- Pass-through: accepted at edge N; `wb_module_enable` is high in cycle N+1. Back-to-back pass-through ops sustain one instruction per cycle.
- Load:
  - Accepted at edge N; `dcache_req_valid` is high from cycle N+1.
  - The request handshakes at edge H (H ≥ N+1).
  - The response, sampled in WAIT, arrives at edge R (R ≥ H+1).
  - `wb_module_enable` is high in cycle R+1.
  - Minimum latency is 3 cycles.
- Store: handshake at edge H; `wb_module_enable` is high in cycle H+1. No response is expected.
- Request stability: `dcache_req_*` do not change while `dcache_req_valid`=1 and `dcache_req_ready`=0.
- Reset mid-operation:
  - Asserting `reset` in REQ or WAIT immediately returns the stage to IDLE and drops `dcache_req_valid`.
  - A later stale response is ignored.
  - No `wb_module_enable` is produced for the aborted instruction.

## Test plan
- Pass-through ADDI:
  - Stimulus: two back-to-back accepts with `alu_result`=0x10, then 0x20.
  - Required: `wb_module_enable` high for 2 consecutive cycles; `alu_result_out` = 0x10, then 0x20; `mem_ready` stays 1.
- LB with sign extension:
  - Stimulus: addr 0x1003; `dcache_resp_data` 0x00000000_80FF0000; ready and response each after 1 cycle.
  - Required: request addr 0x1000; `loaded_data` = 0xFFFF_FFFF_FFFF_FF80; pulse 3 cycles after accept.
- LHU versus LH at addr 0x2002 with response 0x0000_0000_8001_0000:
  - LHU: `loaded_data` = 0x8001.
  - LH: `loaded_data` = 0xFFFF_FFFF_FFFF_8001.
- SH with request backpressure:
  - Stimulus: addr 0x3005, `store_data` 0xABCD; `dcache_req_ready` held low for 4 cycles.
  - Required: `dcache_req_wdata` = 0x00AB_CD00_0000_0000 and `dcache_req_wstrb` = 8'h60, stable through the stall; `mem_ready` = 0 during the stall; pulse in the cycle after the handshake.
- Reset while in WAIT:
  - Stimulus: pulse `reset` in WAIT, then assert `dcache_resp_valid`.
  - Required: no `wb_module_enable`; FSM in IDLE with `mem_ready` = 1; all outputs 0.
